// File: rtl/cmp_share_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_share_pkg
//  Description : Shared types and parameter defaults for the shared
//                comparator arbiter (state encoding, default sizes).
//  Revision    : 1.0 - initial release
// ============================================================================
package cmp_share_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/cmpgt4.sv
`default_nettype none
// ============================================================================
//  Module      : cmpgt4
//  Description : Gate-level 4-bit unsigned magnitude comparator.
//                gt = 1 iff b > a; the most significant differing bit decides.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmpgt4 (
    output wire        gt,
    input  logic [3:0] a,
    input  logic [3:0] b
);

    wire [3:0] w_na;    // ~a
    wire [3:0] w_nb;    // ~b
    wire [3:0] w_g;     // bit i alone says b > a
    wire [3:0] w_l;     // bit i alone says a > b
    wire [3:0] w_e;     // bit i equal
    wire       w_t2;
    wire       w_t1;
    wire       w_t0;

    // Per-bit greater / less / equal terms
    generate
        for (genvar i = 0; i < 4; i++) begin : g_bit
            not u_na (w_na[i], a[i]);
            not u_nb (w_nb[i], b[i]);
            and u_g  (w_g[i], b[i], w_na[i]);
            and u_l  (w_l[i], a[i], w_nb[i]);
            nor u_e  (w_e[i], w_g[i], w_l[i]);
        end
    endgenerate

    // A lower bit only counts when every higher bit is equal
    and u_t2 (w_t2, w_e[3], w_g[2]);
    and u_t1 (w_t1, w_e[3], w_e[2], w_g[1]);
    and u_t0 (w_t0, w_e[3], w_e[2], w_e[1], w_g[0]);
    or  u_gt (gt, w_g[3], w_t2, w_t1, w_t0);

endmodule
`default_nettype wire

// File: rtl/cmp_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_share_arbiter
//  Description : Round-robin arbiter sharing one 4-bit comparator among NREQ
//                requesters. Sequence: IDLE (grant + latch operands) ->
//                EVAL (register comparator result) -> RESP (one-cycle ack).
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_share_arbiter
    import cmp_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   ack,
    output logic              gt,
    output logic [2:0]        gnt_id,
    output logic              busy,
    output logic [7:0]        cmp_count
);

    // First set request bit searching upward from ptr+1, wrapping around.
    // The last-served requester is therefore checked last.
    function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r,
                                           input logic [2:0]      p);
        logic [2:0] sel;
        logic       found;
        sel   = 3'd0;
        found = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && r[j] && (j == (int'(p) + off) % NREQ)) begin
                    sel   = 3'(j);
                    found = 1'b1;
                end
            end
        end
        return sel;
    endfunction

    state_e         state_q;
    state_e         state_d;
    logic [2:0]     gnt_q;
    logic [2:0]     ptr_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           gt_q;
    logic [7:0]     cnt_q;
    logic           w_any;
    logic [2:0]     w_pick;
    logic [W-1:0]   w_a_sel;
    logic [W-1:0]   w_b_sel;
    logic           w_cmp_gt;

    assign w_any  = |req;
    assign w_pick = rr_pick(req, ptr_q);

    // Operand mux for the requester being granted this cycle
    always_comb begin
        w_a_sel = '0;
        w_b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == 3'(i)) begin
                w_a_sel = a_in[i*W +: W];
                w_b_sel = b_in[i*W +: W];
            end
        end
    end

    // The single shared comparator instance
    cmpgt4 u_cmp (
        .gt (w_cmp_gt),
        .a  (a_q),
        .b  (b_q)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: IDLE waits for any request, then a fixed 2-cycle run
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (w_any) state_d = EVAL;
            EVAL:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: grant/operand capture, result register, pointer and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q <= 3'd0;
            ptr_q <= 3'(NREQ - 1);
            a_q   <= '0;
            b_q   <= '0;
            gt_q  <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (w_any) begin
                        gnt_q <= w_pick;
                        a_q   <= w_a_sel;
                        b_q   <= w_b_sel;
                    end
                end
                EVAL: gt_q <= w_cmp_gt;
                RESP: begin
                    ptr_q <= gnt_q;
                    cnt_q <= cnt_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state only; gt is masked outside RESP
    always_comb begin
        ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            ack[i] = (state_q == RESP) && (gnt_q == 3'(i));
        end
        gt        = (state_q == RESP) ? gt_q : 1'b0;
        busy      = (state_q != IDLE);
        gnt_id    = gnt_q;
        cmp_count = cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_cmp_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmp_share_arbiter
//  Description : Self-checking bench for cmp_share_arbiter. Expected grants
//                and results are queued when requests are driven and
//                compared when the DUT acks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req   = '0;
    logic [NREQ*W-1:0] a_in  = '0;
    logic [NREQ*W-1:0] b_in  = '0;
    logic [NREQ-1:0]   ack;
    logic              gt;
    logic [2:0]        gnt_id;
    logic              busy;
    logic [7:0]        cmp_count;

    typedef struct {
        int   id;
        logic gt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt  = 0;

    cmp_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .ack       (ack),
        .gt        (gt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .cmp_count (cmp_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: every ack must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_onehot", 32'(ack), 32'd1 << e.id);
                    chk("gt", 32'(gt), 32'(e.gt));
                    chk("gnt_id", 32'(gnt_id), 32'(e.id));
                end
            end else begin
                chk("gt_no_ack", 32'(gt), 32'd0);
            end
        end
    end

    task automatic set_ops(input int id, input logic [3:0] a, input logic [3:0] b);
        a_in[id*W +: W] = a;
        b_in[id*W +: W] = b;
    endtask

    task automatic push(input int id);
        exp_t e;
        e.id = id;
        e.gt = (b_in[id*W +: W] > a_in[id*W +: W]);
        sb.push_back(e);
    endtask

    // Wait (bounded) for the next ack; lat is the expected count of negedges
    task automatic wait_ack(input int id, input int lat);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (ack == '0 && k < 12);
        if (ack == '0) begin
            chk("ack_timeout", 32'd0, 32'd1);
        end else begin
            chk("ack_latency", 32'(k), 32'(lat));
            chk("ack_bit", 32'(ack[id]), 32'd1);
            chk("busy_resp", 32'(busy), 32'd1);
            exp_cnt = (exp_cnt + 1) % 256;
        end
    endtask

    // Asynchronous reset pulse with reset-value checks while held
    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_gt", 32'(gt), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmp_count", 32'(cmp_count), 32'd0);
        exp_cnt = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_single(input int id, input logic [3:0] a, input logic [3:0] b);
        @(posedge clk);
        #1;
        set_ops(id, a, b);
        push(id);
        req[id] = 1'b1;
        wait_ack(id, 3);
        @(posedge clk);
        #1 req[id] = 1'b0;
        @(negedge clk);
        chk("cmp_count", 32'(cmp_count), 32'(exp_cnt));
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    logic [3:0] t2_a [3] = '{4'd7, 4'hF, 4'h0};
    logic [3:0] t2_b [3] = '{4'd7, 4'hE, 4'h8};

    initial begin
        do_reset();

        // Single request on requester 0
        do_single(0, 4'd3, 4'd9);

        // Equality and reverse cases through requester 2
        for (int i = 0; i < 3; i++) do_single(2, t2_a[i], t2_b[i]);

        // All four held from reset: served 0,1,2,3,0 at 3-cycle spacing
        @(posedge clk);
        #1;
        set_ops(0, 4'd1, 4'd2);
        set_ops(1, 4'd9, 4'd4);
        set_ops(2, 4'd5, 4'd5);
        set_ops(3, 4'd6, 4'hC);
        req = '1;
        do_reset();
        push(0); push(1); push(2); push(3); push(0);
        wait_ack(0, 3);
        wait_ack(1, 3);
        wait_ack(2, 3);
        wait_ack(3, 3);
        wait_ack(0, 3);
        @(posedge clk);
        #1 req = '0;
        @(negedge clk);
        chk("cmp_count_rr", 32'(cmp_count), 32'(exp_cnt));

        // Fairness: req3 arrives while req0 is served, so 3 goes next
        @(posedge clk);
        #1;
        set_ops(0, 4'hA, 4'h3);
        set_ops(3, 4'h2, 4'hB);
        push(0); push(3); push(0);
        req[0] = 1'b1;
        @(posedge clk);
        #1 req[3] = 1'b1;
        wait_ack(0, 2);
        wait_ack(3, 3);
        @(posedge clk);
        #1 req[3] = 1'b0;
        wait_ack(0, 3);
        @(posedge clk);
        #1 req = '0;

        // Reset during EVAL of requester 1 aborts; it is re-served afterwards
        @(posedge clk);
        #1;
        set_ops(1, 4'h4, 4'h5);
        req = 4'b0010;
        @(posedge clk);
        #1;
        chk("busy_eval", 32'(busy), 32'd1);
        do_reset();
        push(1);
        wait_ack(1, 3);
        @(posedge clk);
        #1 req = '0;
        @(negedge clk);
        chk("cmp_count_after_abort", 32'(cmp_count), 32'd1);

        // 256 chained transactions: counter wraps back to 0
        @(posedge clk);
        #1;
        do_reset();
        set_ops(0, 4'($urandom_range(15)), 4'($urandom_range(15)));
        req = 4'b0001;
        for (int i = 0; i < 256; i++) begin
            push(0);
            wait_ack(0, 3);
            if (i == 255) chk("cmp_count_pre_wrap", 32'(cmp_count), 32'd255);
            @(posedge clk);
            #1;
            set_ops(0, 4'($urandom_range(15)), 4'($urandom_range(15)));
            if (i == 255) req = '0;
        end
        @(negedge clk);
        chk("cmp_count_wrap", 32'(cmp_count), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
